// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status logic for an asynchronous FIFO.
// It keeps a binary/Gray write pointer and registered full, almost-full, free-count and sticky overflow flags.
module wptr_full_ctrl #(
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wfree,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] DEPTH_C = {1'b1, {ADDRSIZE{1'b0}}};

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] wbin_r;
  logic [ADDRSIZE:0] wptr_r;
  logic              wfull_r;
  logic              walmost_full_r;
  logic [ADDRSIZE:0] wfree_r;
  logic              woverflow_r;

  logic [ADDRSIZE:0] wbinnext_s;
  logic [ADDRSIZE:0] wgraynext_s;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] used_next_s;

  // Next pointer and occupancy as they will stand after this edge.
  always_comb begin
    wbinnext_s  = wbin_r + {{ADDRSIZE{1'b0}}, (winc & ~wfull_r)};
    wgraynext_s = bin2gray(wbinnext_s);
    rbin_s      = gray2bin(wq2_rptr);
    used_next_s = wbinnext_s - rbin_s;
  end

  // Pointer and status registers; flags use next-state occupancy so they track wptr with no lag.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_r         <= {(ADDRSIZE+1){1'b0}};
      wptr_r         <= {(ADDRSIZE+1){1'b0}};
      wfull_r        <= 1'b0;
      walmost_full_r <= 1'b0;
      wfree_r        <= DEPTH_C;
      woverflow_r    <= 1'b0;
    end else begin
      wbin_r         <= wbinnext_s;
      wptr_r         <= wgraynext_s;
      wfull_r        <= (used_next_s == DEPTH_C);
      walmost_full_r <= (used_next_s >= afull_thresh);
      wfree_r        <= DEPTH_C - used_next_s;
      // A new overflow outranks a simultaneous clear.
      if (winc & wfull_r) begin
        woverflow_r <= 1'b1;
      end else if (wovf_clr) begin
        woverflow_r <= 1'b0;
      end else begin
        woverflow_r <= woverflow_r;
      end
    end
  end

  assign waddr        = wbin_r[ADDRSIZE-1:0];
  assign wptr         = wptr_r;
  assign wfull        = wfull_r;
  assign walmost_full = walmost_full_r;
  assign wfree        = wfree_r;
  assign woverflow    = woverflow_r;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed self-checking bench for wptr_full_ctrl with ADDRSIZE = 4 (DEPTH = 16).
module tb_wptr_full_ctrl;

  logic       wclk;
  logic       wrst;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic [4:0] afull_thresh;
  logic       wovf_clr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wfree;
  logic       woverflow;

  int checks   = 0;
  int failures = 0;

  wptr_full_ctrl #(.ADDRSIZE(4)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .afull_thresh (afull_thresh),
    .wovf_clr     (wovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wfree        (wfree),
    .woverflow    (woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wptr"}, 32'(wptr), 32'd0);
    chk({tag, "_waddr"}, 32'(waddr), 32'd0);
    chk({tag, "_wfull"}, 32'(wfull), 32'd0);
    chk({tag, "_walmost"}, 32'(walmost_full), 32'd0);
    chk({tag, "_wfree"}, 32'(wfree), 32'd16);
    chk({tag, "_wovf"}, 32'(woverflow), 32'd0);
  endtask

  initial begin
    wrst = 1'b1; winc = 1'b0; wq2_rptr = 5'd0; afull_thresh = 5'd12; wovf_clr = 1'b0;
    step();
    step();
    chk_reset_state("reset");

    // Threshold 0: almost-full on the first edge with the FIFO empty
    wrst = 1'b0; afull_thresh = 5'd0;
    step();
    chk("thr0_walmost", 32'(walmost_full), 32'd1);
    chk("thr0_wfree", 32'(wfree), 32'd16);

    // Fill 16 words with threshold 12
    afull_thresh = 5'd12; winc = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("fill_wptr", 32'(wptr), 32'(gray(k)));
      chk("fill_wfree", 32'(wfree), 32'(16 - k));
      chk("fill_walmost", 32'(walmost_full), (k >= 12) ? 32'd1 : 32'd0);
      chk("fill_wfull", 32'(wfull), (k == 16) ? 32'd1 : 32'd0);
    end
    chk("full_wptr_11000", 32'(wptr), 32'b11000);

    // Overflow attempt: pointer holds, sticky flag sets
    step();
    chk("ovf_wptr", 32'(wptr), 32'b11000);
    chk("ovf_waddr", 32'(waddr), 32'd0);
    chk("ovf_flag", 32'(woverflow), 32'd1);
    chk("ovf_wfull", 32'(wfull), 32'd1);
    wovf_clr = 1'b1;
    step();
    chk("ovf_set_wins", 32'(woverflow), 32'd1);
    winc = 1'b0;
    step();
    chk("ovf_clear", 32'(woverflow), 32'd0);
    wovf_clr = 1'b0;

    // Drain: reader pointer to binary 4
    wq2_rptr = 5'b00110;
    step();
    chk("drain_wfull", 32'(wfull), 32'd0);
    chk("drain_wfree", 32'(wfree), 32'd4);
    chk("drain_walmost", 32'(walmost_full), 32'd1);

    // Threshold 16: almost-full follows full exactly
    afull_thresh = 5'd16;
    step();
    chk("thr16_walmost0", 32'(walmost_full), 32'd0);
    winc = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("thr16_wfull", 32'(wfull), (k == 4) ? 32'd1 : 32'd0);
      chk("thr16_walmost", 32'(walmost_full), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("thr16_wptr", 32'(wptr), 32'b11110);

    // Reset with winc asserted
    wrst = 1'b1;
    step();
    chk_reset_state("reset2");

    // Reach full at wbin = 7 (reader binary 23), overflow, then reset mid-run
    wrst = 1'b0; wq2_rptr = 5'b11100; afull_thresh = 5'd12;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("b7_wfree", 32'(wfree), 32'(7 - k));
    end
    chk("b7_wfull", 32'(wfull), 32'd1);
    chk("b7_waddr", 32'(waddr), 32'd7);
    step();
    chk("b7_ovf", 32'(woverflow), 32'd1);
    chk("b7_waddr_hold", 32'(waddr), 32'd7);
    wrst = 1'b1;
    step();
    chk_reset_state("reset_mid");

    // Wrap: 40 writes with the reader two behind
    wrst = 1'b0; wq2_rptr = 5'd0; afull_thresh = 5'd16;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("wrap_wptr", 32'(wptr), 32'(gray(k)));
      chk("wrap_wfull", 32'(wfull), 32'd0);
      chk("wrap_wfree", 32'(wfree), (k >= 2) ? 32'd14 : 32'(16 - k));
      if (k == 31) chk("wrap_wptr_10000", 32'(wptr), 32'b10000);
      if (k == 32) chk("wrap_wptr_00000", 32'(wptr), 32'b00000);
      wq2_rptr = gray(k - 1);
    end
    winc = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
